// File: rtl/tron_game_ctrl_if.sv
// Control bus between the game sequencer and its neighbours.
//   start, frame_end, p1_collide, p2_collide : into the sequencer
//   dflt, clear_trace, step, countdown_active,
//   round_result, p1_score, p2_score, match_over : out of the sequencer
// master = the side driving start/frame_end/collisions, slave = the sequencer.
interface tron_game_ctrl_if #(
   parameter int SCORE_W = 3
);
   logic               start;
   logic               frame_end;
   logic               p1_collide;
   logic               p2_collide;
   logic               dflt;
   logic               clear_trace;
   logic               step;
   logic               countdown_active;
   logic [1:0]         round_result;
   logic [SCORE_W-1:0] p1_score;
   logic [SCORE_W-1:0] p2_score;
   logic               match_over;

   modport master (
      output start, frame_end, p1_collide, p2_collide,
      input  dflt, clear_trace, step, countdown_active,
             round_result, p1_score, p2_score, match_over
   );

   modport slave (
      input  start, frame_end, p1_collide, p2_collide,
      output dflt, clear_trace, step, countdown_active,
             round_result, p1_score, p2_score, match_over
   );
endinterface

// File: rtl/tron_game_ctrl.sv
// Round/match sequencer for the two-player light-cycle game.
// All timing is counted in frame_end pulses from the VGA timing block.
// Ports:
//   clock  : system clock
//   reset  : synchronous, active-high reset
//   bus    : tron_game_ctrl_if.slave (start/frame_end/collisions in,
//            datapath controls, round result and scores out)
module tron_game_ctrl #(
   parameter int FRAMES_PER_STEP  = 2,
   parameter int COUNTDOWN_FRAMES = 180,
   parameter int RESULT_FRAMES    = 120,
   parameter int WIN_SCORE        = 3,
   parameter int SCORE_W          = 3
) (
   input  logic             clock,
   input  logic             reset,
   tron_game_ctrl_if.slave  bus
);
   localparam int CNT_MAX = (COUNTDOWN_FRAMES > RESULT_FRAMES) ? COUNTDOWN_FRAMES
                                                               : RESULT_FRAMES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int DIV_W   = $clog2(FRAMES_PER_STEP) + 1;

   typedef enum logic [2:0] {
      IDLE, CLEAR, COUNTDOWN, PLAY, ROUND_END, MATCH_END
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [DIV_W-1:0]   div;
   logic [1:0]         result;
   logic [SCORE_W-1:0] p1_score;
   logic [SCORE_W-1:0] p2_score;
   logic               collide;

   assign collide = bus.p1_collide | bus.p2_collide;

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         div      <= '0;
         result   <= 2'b00;
         p1_score <= '0;
         p2_score <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) state <= CLEAR;
            end
            // Leaving on the first frame_end after entry guarantees one
            // full frame of clear_trace, because entry never happens on
            // a frame_end that CLEAR itself observes.
            CLEAR: begin
               if (bus.frame_end) begin
                  state  <= COUNTDOWN;
                  result <= 2'b00;
                  cnt    <= '0;
               end
            end
            COUNTDOWN: begin
               if (bus.frame_end) begin
                  if (cnt == CNT_W'(COUNTDOWN_FRAMES - 1)) begin
                     state <= PLAY;
                     cnt   <= '0;
                     div   <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            PLAY: begin
               if (collide) begin
                  state  <= ROUND_END;
                  cnt    <= '0;
                  result <= {bus.p1_collide, bus.p2_collide};
                  // Only the survivor scores; a draw leaves both alone.
                  if (bus.p2_collide && !bus.p1_collide &&
                      p1_score != SCORE_W'(WIN_SCORE))
                     p1_score <= p1_score + 1'b1;
                  if (bus.p1_collide && !bus.p2_collide &&
                      p2_score != SCORE_W'(WIN_SCORE))
                     p2_score <= p2_score + 1'b1;
               end else if (bus.frame_end) begin
                  if (div == DIV_W'(FRAMES_PER_STEP - 1)) div <= '0;
                  else                                    div <= div + 1'b1;
               end
            end
            ROUND_END: begin
               if (bus.frame_end) begin
                  if (cnt == CNT_W'(RESULT_FRAMES - 1)) begin
                     cnt <= '0;
                     if (p1_score == SCORE_W'(WIN_SCORE) ||
                         p2_score == SCORE_W'(WIN_SCORE))
                        state <= MATCH_END;
                     else
                        state <= CLEAR;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            MATCH_END: begin
               if (bus.start) begin
                  state    <= CLEAR;
                  p1_score <= '0;
                  p2_score <= '0;
                  result   <= 2'b00;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // step is the only output not taken purely from registered state: it must
   // coincide with the frame_end it qualifies, and a collision vetoes it.
   assign bus.step = (state == PLAY) && bus.frame_end && !collide &&
                     (div == DIV_W'(FRAMES_PER_STEP - 1));

   assign bus.dflt             = (state != PLAY);
   assign bus.clear_trace      = (state == CLEAR);
   assign bus.countdown_active = (state == COUNTDOWN);
   assign bus.match_over       = (state == MATCH_END);
   assign bus.round_result     = result;
   assign bus.p1_score         = p1_score;
   assign bus.p2_score         = p2_score;
endmodule

// File: tb/tb_tron_game_ctrl.sv
// Testbench for tron_game_ctrl: constant vector table for the opening
// round, hand sequences for the corner cases, then random stimulus, all
// cross-checked every cycle against a frame-counting reference model.
module tb_tron_game_ctrl;
   localparam int FPS  = 2;
   localparam int CDF  = 3;
   localparam int RF   = 2;
   localparam int WIN  = 2;
   localparam int SW   = 3;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   tron_game_ctrl_if #(.SCORE_W(SW)) bus ();

   tron_game_ctrl #(
      .FRAMES_PER_STEP(FPS), .COUNTDOWN_FRAMES(CDF), .RESULT_FRAMES(RF),
      .WIN_SCORE(WIN), .SCORE_W(SW)
   ) dut (
      .clock(clock), .reset(reset), .bus(bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: phase plus frames-remaining, and a running count of
   // frames played to place the steps.
   localparam int M_IDLE = 0, M_CLEAR = 1, M_CD = 2, M_PLAY = 3, M_RE = 4, M_ME = 5;
   int m_ph = M_IDLE;
   int m_left = 0;
   int m_pf = 0;
   int m_s1 = 0, m_s2 = 0, m_rr = 0;

   task automatic model(input logic rs, st, fe, c1, c2);
      if (rs) begin
         m_ph = M_IDLE; m_s1 = 0; m_s2 = 0; m_rr = 0;
      end else begin
         case (m_ph)
            M_IDLE:  if (st) m_ph = M_CLEAR;
            M_CLEAR: if (fe) begin m_ph = M_CD; m_left = CDF; m_rr = 0; end
            M_CD:    if (fe) begin
                        m_left--;
                        if (m_left == 0) begin m_ph = M_PLAY; m_pf = 0; end
                     end
            M_PLAY:  if (c1 || c2) begin
                        m_rr = (c1 ? 2 : 0) + (c2 ? 1 : 0);
                        if (c2 && !c1 && m_s1 < WIN) m_s1++;
                        if (c1 && !c2 && m_s2 < WIN) m_s2++;
                        m_ph = M_RE; m_left = RF;
                     end else if (fe) m_pf++;
            M_RE:    if (fe) begin
                        m_left--;
                        if (m_left == 0) m_ph = (m_s1 == WIN || m_s2 == WIN) ? M_ME : M_CLEAR;
                     end
            M_ME:    if (st) begin m_ph = M_CLEAR; m_s1 = 0; m_s2 = 0; m_rr = 0; end
            default: m_ph = M_IDLE;
         endcase
      end
   endtask

   logic s_step;

   // One clock: drive inputs, check combinational step, clock, check state.
   task automatic cyc(input logic rs, st, fe, c1, c2);
      logic exp_step;
      reset = rs; bus.start = st; bus.frame_end = fe;
      bus.p1_collide = c1; bus.p2_collide = c2;
      #1;
      exp_step = (m_ph == M_PLAY) && fe && !c1 && !c2 && (m_pf % FPS == FPS - 1);
      s_step = bus.step;
      if (!rs) chk("step", int'(s_step), int'(exp_step));
      @(posedge clock);
      model(rs, st, fe, c1, c2);
      #1;
      chk("dflt",        int'(bus.dflt),             int'(m_ph != M_PLAY));
      chk("clear_trace", int'(bus.clear_trace),      int'(m_ph == M_CLEAR));
      chk("countdown",   int'(bus.countdown_active), int'(m_ph == M_CD));
      chk("match_over",  int'(bus.match_over),       int'(m_ph == M_ME));
      chk("round_result", int'(bus.round_result),    m_rr);
      chk("p1_score",    int'(bus.p1_score),         m_s1);
      chk("p2_score",    int'(bus.p2_score),         m_s2);
   endtask

   typedef struct {
      logic st, fe, c1, c2;
      logic stp, dflt, clr, cd, mo;
      int   rr, s1, s2;
   } vec_t;
   vec_t vq[$];

   task automatic add(input logic st, fe, c1, c2, stp, dflt, clr, cd,
                      input int rr, s1, s2, input logic mo);
      vec_t v;
      v.st = st; v.fe = fe; v.c1 = c1; v.c2 = c2; v.stp = stp; v.dflt = dflt;
      v.clr = clr; v.cd = cd; v.rr = rr; v.s1 = s1; v.s2 = s2; v.mo = mo;
      vq.push_back(v);
   endtask

   initial begin
      bus.start = 0; bus.frame_end = 0; bus.p1_collide = 0; bus.p2_collide = 0;
      reset = 1;

      //   st fe c1 c2 | stp dflt clr cd rr s1 s2 mo
      // idle: frame_end ignored
      for (int i = 0; i < 5; i++) add(0,1,0,0, 0,1,0,0, 0,0,0,0);
      add(1,0,0,0, 0,1,1,0, 0,0,0,0);   // start -> CLEAR
      add(0,0,0,0, 0,1,1,0, 0,0,0,0);
      add(0,1,0,0, 0,1,0,1, 0,0,0,0);   // frame_end -> COUNTDOWN
      add(0,1,0,0, 0,1,0,1, 0,0,0,0);
      add(0,0,0,0, 0,1,0,1, 0,0,0,0);
      add(0,1,0,0, 0,1,0,1, 0,0,0,0);
      add(0,1,0,0, 0,0,0,0, 0,0,0,0);   // 3rd countdown frame -> PLAY
      add(0,1,0,0, 0,0,0,0, 0,0,0,0);
      add(0,0,0,0, 0,0,0,0, 0,0,0,0);
      add(0,1,0,0, 1,0,0,0, 0,0,0,0);   // 2nd play frame steps
      add(0,1,0,0, 0,0,0,0, 0,0,0,0);
      add(0,1,0,0, 1,0,0,0, 0,0,0,0);   // 4th play frame steps
      add(0,0,0,1, 0,1,0,0, 1,1,0,0);   // p2 crashes: P1 wins
      add(0,1,0,0, 0,1,0,0, 1,1,0,0);
      add(0,1,0,0, 0,1,1,0, 1,1,0,0);   // result over -> CLEAR, result held
      add(0,1,0,0, 0,1,0,1, 0,1,0,0);   // CLEAR exit clears result

      cyc(1,0,0,0,0);
      cyc(1,0,0,0,0);
      chk("reset_dflt", int'(bus.dflt), 1);
      chk("reset_score", int'(bus.p1_score) + int'(bus.p2_score), 0);

      foreach (vq[i]) begin
         cyc(0, vq[i].st, vq[i].fe, vq[i].c1, vq[i].c2);
         chk($sformatf("v%0d_step", i), int'(s_step),               int'(vq[i].stp));
         chk($sformatf("v%0d_dflt", i), int'(bus.dflt),             int'(vq[i].dflt));
         chk($sformatf("v%0d_clr", i),  int'(bus.clear_trace),      int'(vq[i].clr));
         chk($sformatf("v%0d_cd", i),   int'(bus.countdown_active), int'(vq[i].cd));
         chk($sformatf("v%0d_rr", i),   int'(bus.round_result),     vq[i].rr);
         chk($sformatf("v%0d_s1", i),   int'(bus.p1_score),         vq[i].s1);
         chk($sformatf("v%0d_s2", i),   int'(bus.p2_score),         vq[i].s2);
         chk($sformatf("v%0d_mo", i),   int'(bus.match_over),       int'(vq[i].mo));
      end

      // Draw on a step-eligible frame: no step, no score change.
      repeat (3) cyc(0,0,1,0,0);
      cyc(0,0,1,0,0);
      cyc(0,0,1,1,1);
      chk("draw_step", int'(s_step), 0);
      chk("draw_rr", int'(bus.round_result), 3);
      chk("draw_s1", int'(bus.p1_score), 1);
      chk("draw_s2", int'(bus.p2_score), 0);

      // P1 takes the second round -> match end, then restart.
      repeat (2) cyc(0,0,1,0,0);
      cyc(0,0,1,0,0);
      repeat (3) cyc(0,0,1,0,0);
      cyc(0,0,0,0,1);
      repeat (2) cyc(0,0,1,0,0);
      chk("match_over", int'(bus.match_over), 1);
      chk("match_s1", int'(bus.p1_score), 2);
      cyc(0,0,1,1,0);                  // collisions ignored in MATCH_END
      chk("match_hold_s2", int'(bus.p2_score), 0);
      cyc(0,1,1,0,0);                  // restart coincident with frame_end
      chk("restart_s1", int'(bus.p1_score), 0);
      chk("restart_rr", int'(bus.round_result), 0);
      chk("restart_clr", int'(bus.clear_trace), 1);
      cyc(0,0,0,0,0);
      chk("restart_clr_held", int'(bus.clear_trace), 1);

      // start in COUNTDOWN is ignored; then reset mid-PLAY with a score.
      cyc(0,0,1,0,0);
      repeat (3) cyc(0,0,1,0,0);
      cyc(0,0,0,0,1);
      repeat (2) cyc(0,0,1,0,0);
      cyc(0,0,1,0,0);
      cyc(0,0,1,0,0);
      cyc(0,1,0,0,0);
      cyc(0,0,1,0,0);
      chk("cd_start_ignored", int'(bus.countdown_active), 1);
      cyc(0,0,1,0,0);
      chk("cd_len", int'(bus.countdown_active), 0);
      chk("cd_play", int'(bus.dflt), 0);
      chk("pre_reset_s1", int'(bus.p1_score), 1);
      cyc(1,0,0,0,0);
      chk("rst_dflt", int'(bus.dflt), 1);
      chk("rst_s1", int'(bus.p1_score), 0);
      chk("rst_idle", int'(bus.clear_trace) + int'(bus.countdown_active) + int'(bus.match_over), 0);

      // Random play against the model.
      for (int i = 0; i < 6000; i++) begin
         cyc(($urandom_range(0, 799) == 0),
             ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 11) == 0),
             ($urandom_range(0, 11) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/tron_game_ctrl.md
Name: tron_game_ctrl

Overview:
- Round/match sequencer for the two-player light-cycle game.
- Drives the default-position hold (dflt), trace clearing and per-step movement enable for the player-drawing datapath.
- Consumes the datapath's per-player collision flags and keeps score.
- Sits between the button/input synchroniser and the object-drawing block; all timing derives from the VGA end-of-frame pulse.

Parameters:
FRAMES_PER_STEP, 2, frame_end pulses per movement step in PLAY (>=1)
COUNTDOWN_FRAMES, 180, frame_end pulses spent in COUNTDOWN (>=1)
RESULT_FRAMES, 120, frame_end pulses spent in ROUND_END (>=1)
WIN_SCORE, 3, round wins needed to end the match (1..2^SCORE_W-1)
SCORE_W, 3, width of score outputs

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle, already synchronised start/restart pulse
frame_end  in  1  one-cycle pulse when row==599 and col==799
p1_collide  in  1  player 1 head overlaps a trace or a wall (level)
p2_collide  in  1  player 2 head overlaps a trace or a wall (level)
dflt  out  1  force players to start positions
clear_trace  out  1  clear both trace stores
step  out  1  one-cycle movement/trace-commit enable
countdown_active  out  1  high in COUNTDOWN
round_result  out  2  00 none, 01 P1 won, 10 P2 won, 11 draw
p1_score  out  SCORE_W  player 1 round wins
p2_score  out  SCORE_W  player 2 round wins
match_over  out  1  high in MATCH_END

Behaviour:
- Reset (synchronous, highest priority, any state):
  - State goes to IDLE.
  - Scores, round_result, frame counter and step divider are set to 0.
  - Output values after reset: dflt=1, clear_trace=0, step=0, countdown_active=0, match_over=0.
- States: IDLE, CLEAR, COUNTDOWN, PLAY, ROUND_END, MATCH_END. State and counters are registered.
- Output decode (from registered state, except step):
  - dflt=1 in every state except PLAY.
  - clear_trace=1 in CLEAR only.
  - countdown_active=1 in COUNTDOWN only.
  - match_over=1 in MATCH_END only.
- IDLE: start -> CLEAR. frame_end is ignored.
- CLEAR:
  - Stays until the first frame_end after entry, then -> COUNTDOWN.
  - On that exit, round_result <- 00 and frame counter <- 0.
  - This guarantees one full frame of clear_trace.
- COUNTDOWN:
  - Frame counter increments on each frame_end.
  - On the frame_end where counter == COUNTDOWN_FRAMES-1: -> PLAY, counter <- 0, divider <- 0.
- PLAY:
  - step is combinational: state==PLAY && frame_end && divider==FRAMES_PER_STEP-1 && !p1_collide && !p2_collide.
  - divider increments on each frame_end and wraps to 0 at FRAMES_PER_STEP-1.
  - Any cycle with p1_collide|p2_collide: -> ROUND_END next cycle. A collision suppresses a coincident step.
  - round_result <- {p1_collide, p2_collide} mapped as: both=11 draw, p1 only=10 (P2 wins), p2 only=01 (P1 wins).
  - The winner's score increments in the same cycle. A draw changes neither score.
  - Scores saturate at WIN_SCORE.
- ROUND_END:
  - Counts RESULT_FRAMES frame_end pulses.
  - On the last one: if p1_score==WIN_SCORE or p2_score==WIN_SCORE -> MATCH_END, else -> CLEAR.
  - round_result is held.
- MATCH_END:
  - Scores and round_result are held.
  - start -> CLEAR, with both scores <- 0 and round_result <- 00 in that cycle.
- start is ignored in CLEAR, COUNTDOWN, PLAY and ROUND_END.
- start coincident with frame_end in IDLE/MATCH_END: enter CLEAR. That frame_end does not count as CLEAR's exit pulse.
- Collision inputs are ignored outside PLAY.
- Counter width: $clog2 of max(COUNTDOWN_FRAMES, RESULT_FRAMES)+1. Divider width: $clog2(FRAMES_PER_STEP)+1.

Test Plan:
All scenarios use FRAMES_PER_STEP=2, COUNTDOWN_FRAMES=3, RESULT_FRAMES=2, WIN_SCORE=2.
1. Reset, then 5 frame_end with no start -> dflt=1, step never asserts, scores 0. Then start + 1 frame_end -> clear_trace high exactly until that frame_end, countdown_active high next cycle.
2. Countdown: after CLEAR, 3 frame_end -> countdown_active drops after the 3rd and dflt=0. The next 4 frame_end produce step on the 2nd and 4th only.
3. In PLAY, p2_collide pulse for 1 cycle -> next cycle round_result=01, p1_score=1, dflt=1. After 2 frame_end -> clear_trace=1 (new round).
4. p1_collide and p2_collide together, coincident with a step-eligible frame_end -> step=0, round_result=11, both scores unchanged.
5. P1 wins two rounds -> after the second ROUND_END completes, match_over=1, p1_score=2. start then forces scores 0/0, round_result=00, state CLEAR.
6. Assert reset for 1 cycle mid-PLAY with p1_score=1 -> next cycle IDLE, dflt=1, scores 0. start during COUNTDOWN is ignored (countdown length unchanged at 3 frames).
